vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Display timing generator for the RojoBot world display, clocked from the 100 MHz system clock.
- Derives an internal pixel-enable tick instead of a separate pixel clock.
- Produces 640x480@60 Hz sync, video-enable and pixel row/column.
- Also produces pre-scaled 128x128 world-map coordinates and an in-world flag. These feed the bot world-map read port, the icon block and the colorizer directly, so no external bit-slicing is needed.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); must be >= 2
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive low; 0 = sync pulses drive high
REZ_SHIFT, 2, right-shift from pixel coordinates to world coordinates
WORLD_PIX, 512, width and height of the world window in screen pixels

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
pix_tick  output  1  one-clk pulse once every CLK_DIV clocks; counters advance on the edge ending this cycle
hsync  output  1  horizontal sync (polarity per SYNC_ACTIVE_LOW)
vsync  output  1  vertical sync (polarity per SYNC_ACTIVE_LOW)
video_on  output  1  high while the current pixel is in the visible area
pixel_column  output  10  horizontal counter, 0..H_TOTAL-1
pixel_row  output  10  vertical counter, 0..V_TOTAL-1
world_col  output  7  pixel_column >> REZ_SHIFT, truncated to 7 bits
world_row  output  7  pixel_row >> REZ_SHIFT, truncated to 7 bits
in_world  output  1  video_on && pixel_column < WORLD_PIX && pixel_row < WORLD_PIX
line_start  output  1  one-clk pulse, first clk with pixel_column == 0
frame_start  output  1  one-clk pulse, first clk with pixel_column == 0 and pixel_row == 0

Behaviour:
- Totals:
  - H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP (800 at defaults).
  - V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP (525 at defaults).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div_cnt == CLK_DIV-1), and is registered-equivalent (glitch-free).
- Counters:
  - On a clk edge where pix_tick is high, pixel_column increments.
  - At H_TOTAL-1, pixel_column wraps to 0 and pixel_row increments.
  - pixel_row wraps from V_TOTAL-1 to 0 only when pixel_column also wraps.
  - Counters hold on all other edges.
- Outputs:
  - All outputs are registered and change only on the edge that advances the counters.
  - Every output is a pure function of the current counter values; there is no extra pipeline latency.
  - Each pixel state therefore lasts exactly CLK_DIV clocks.
- Decode (sync active level shown):
  - hsync active when H_VISIBLE+H_FP <= col < H_VISIBLE+H_FP+H_SYNC (656..751).
  - vsync active when V_VISIBLE+V_FP <= row < V_VISIBLE+V_FP+V_SYNC (490..491).
  - video_on when col < H_VISIBLE && row < V_VISIBLE.
- line_start / frame_start:
  - Asserted for exactly the first clk of the corresponding counter state, not for all CLK_DIV clocks.
- World window:
  - Lines 480..511 of the world are off-screen; in_world is never high there.
  - world_row/world_col are valid only when in_world = 1.
  - Outside that condition their values are don't-care but deterministic (always the shifted counter).
- Reset (synchronous, overrides everything):
  - div_cnt = 0, pixel_column = H_TOTAL-1 (799), pixel_row = V_TOTAL-1 (524).
  - hsync and vsync inactive, video_on = 0, in_world = 0, pix_tick = 0, line_start = 0, frame_start = 0.
  - world_row/world_col = shifted reset counters.
  - The first pix_tick after reset therefore wraps both counters to (0,0) and fires frame_start.
- Reset mid-frame: asserting rst at any point forces the reset state on the next edge, with no partial pulses. Sync outputs go inactive immediately even if they were mid-pulse.
- Timing after reset release (rst low from edge E0, CLK_DIV = 4):
  - pix_tick is high in the 4th clk.
  - Counters read (0,0), with frame_start and line_start high, from the 5th clk onward.

Test Plan:
- Reset release: pix_tick first high in clk 4; clk 5 shows col=0, row=0, video_on=1, in_world=1, frame_start=1 for one clk only.
- Tick cadence: over 40 clks, pix_tick high exactly 10 times, spaced 4 apart. Line period 3200 clks, frame period 1,680,000 clks, each measured between frame_start pulses.
- Hsync: low from col 656 through col 751, i.e. exactly 384 clks. High at col 655 and col 752. Repeat with SYNC_ACTIVE_LOW=0 and confirm inverted polarity.
- Vsync/video_on: vsync low for exactly 6400 clks (rows 490–491). video_on low for all col >= 640 and all row >= 480.
- World mapping: col=511,row=0 gives in_world=1, world_col=127. col=512 gives in_world=0. col=300,row=200 gives world_col=75, world_row=50.
- Mid-pulse reset: assert rst for 1 clk while hsync is low at col 700. Next edge gives hsync=1, col=799, row=524. frame_start fires 4 clks after release.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Display timing bundle from the VGA timing generator to the display pipeline
// (world-map read port, icon block, colorizer, DAC sync pins).
interface vga_timing_gen_if;
   logic       pix_tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_column;
   logic [9:0] pixel_row;
   logic [6:0] world_col;
   logic [6:0] world_row;
   logic       in_world;
   logic       line_start;
   logic       frame_start;

   modport master (
      output pix_tick, hsync, vsync, video_on, pixel_column, pixel_row,
             world_col, world_row, in_world, line_start, frame_start
   );

   modport slave (
      input  pix_tick, hsync, vsync, video_on, pixel_column, pixel_row,
             world_col, world_row, in_world, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from the system clock via a pixel-enable tick, with
// pre-scaled 128x128 world-map coordinates for the RojoBot display path.
module vga_timing_gen #(
   parameter int CLK_DIV         = 4,
   parameter int H_VISIBLE       = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int REZ_SHIFT       = 2,
   parameter int WORLD_PIX       = 512
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

   localparam logic [9:0] COL_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] ROW_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] WORLD    = 10'(WORLD_PIX);
   localparam logic       SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

   logic [DIV_W-1:0] div_cnt;
   logic             pix_tick_q;
   logic [9:0]       col_q, row_q;
   logic             hsync_q, vsync_q, video_on_q, in_world_q;
   logic [6:0]       world_col_q, world_row_q;
   logic             line_start_q, frame_start_q;

   logic [9:0]       col_nxt, row_nxt;
   logic             hs_act, vs_act, vid_nxt;

   // Decode is done on the next counter value so registered outputs line up
   // with the counters on the same advancing edge.
   always_comb begin
      col_nxt = col_q + 10'd1;
      row_nxt = row_q;
      if (col_q == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
      end
      hs_act  = (col_nxt >= HS_BEG) && (col_nxt < HS_END);
      vs_act  = (row_nxt >= VS_BEG) && (row_nxt < VS_END);
      vid_nxt = (col_nxt < H_VIS) && (row_nxt < V_VIS);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt       <= '0;
         pix_tick_q    <= 1'b0;
         col_q         <= COL_LAST;
         row_q         <= ROW_LAST;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         video_on_q    <= 1'b0;
         in_world_q    <= 1'b0;
         world_col_q   <= 7'(COL_LAST >> REZ_SHIFT);
         world_row_q   <= 7'(ROW_LAST >> REZ_SHIFT);
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt       <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         // Registered one cycle early so the tick lands on div_cnt == CLK_DIV-1.
         pix_tick_q    <= (div_cnt == DIV_PRE);
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         if (pix_tick_q) begin
            col_q         <= col_nxt;
            row_q         <= row_nxt;
            hsync_q       <= hs_act ^ SYNC_OFF;
            vsync_q       <= vs_act ^ SYNC_OFF;
            video_on_q    <= vid_nxt;
            in_world_q    <= vid_nxt && (col_nxt < WORLD) && (row_nxt < WORLD);
            world_col_q   <= 7'(col_nxt >> REZ_SHIFT);
            world_row_q   <= 7'(row_nxt >> REZ_SHIFT);
            line_start_q  <= (col_nxt == '0);
            frame_start_q <= (col_nxt == '0) && (row_nxt == '0);
         end
      end
   end

   assign vga.pix_tick     = pix_tick_q;
   assign vga.hsync        = hsync_q;
   assign vga.vsync        = vsync_q;
   assign vga.video_on     = video_on_q;
   assign vga.pixel_column = col_q;
   assign vga.pixel_row    = row_q;
   assign vga.world_col    = world_col_q;
   assign vga.world_row    = world_row_q;
   assign vga.in_world     = in_world_q;
   assign vga.line_start   = line_start_q;
   assign vga.frame_start  = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry, inverted sync polarity and a
// shrunken geometry that wraps whole frames, all against an arithmetic model.
module tb_vga_timing_gen;
   typedef struct packed {
      logic       pix_tick;
      logic       hsync;
      logic       vsync;
      logic       video_on;
      logic [9:0] col;
      logic [9:0] row;
      logic [6:0] wcol;
      logic [6:0] wrow;
      logic       in_world;
      logic       line_start;
      logic       frame_start;
   } out_t;

   typedef struct {
      int cd, hv, hf, hs, hb, vv, vf, vs, vb, low, rz, wp;
   } geom_t;

   typedef struct {
      string name;
      int    m;
      out_t  exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_gen_if va ();
   vga_timing_gen_if vb ();
   vga_timing_gen_if vc ();

   vga_timing_gen dut_a (.clk(clk), .rst(rst), .vga(va));
   vga_timing_gen #(.SYNC_ACTIVE_LOW(0)) dut_b (.clk(clk), .rst(rst), .vga(vb));
   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .REZ_SHIFT(1), .WORLD_PIX(16)
   ) dut_c (.clk(clk), .rst(rst), .vga(vc));

   out_t act_a, act_b, act_c;
   assign act_a = {va.pix_tick, va.hsync, va.vsync, va.video_on, va.pixel_column, va.pixel_row,
                   va.world_col, va.world_row, va.in_world, va.line_start, va.frame_start};
   assign act_b = {vb.pix_tick, vb.hsync, vb.vsync, vb.video_on, vb.pixel_column, vb.pixel_row,
                   vb.world_col, vb.world_row, vb.in_world, vb.line_start, vb.frame_start};
   assign act_c = {vc.pix_tick, vc.hsync, vc.vsync, vc.video_on, vc.pixel_column, vc.pixel_row,
                   vc.world_col, vc.world_row, vc.in_world, vc.line_start, vc.frame_start};

   geom_t ga = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1, 2, 512};
   geom_t gb = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 2, 512};
   geom_t gc = '{2, 20, 2, 3, 3, 12, 2, 2, 2, 1, 1, 16};

   int n_vec = 0;
   int n_bad = 0;
   int m = 0;
   bit measure = 1'b0;
   int tick_cnt = 0, hs_low_a = 0, hs_high_b = 0;
   int last_ls_a = -1, last_fs_c = -1, vs_low_c = 0;

   // m = clocks since the last reset edge; the screen position is the number
   // of completed pixel periods, folded into the line and frame totals.
   function automatic out_t model(input int mm, input geom_t g);
      out_t e;
      int ht    = g.hv + g.hf + g.hs + g.hb;
      int vt    = g.vv + g.vf + g.vs + g.vb;
      int ticks = mm / g.cd;
      int col, row;
      bit hs_act, vs_act;
      if (ticks == 0) begin
         col = ht - 1;
         row = vt - 1;
      end else begin
         col = (ticks - 1) % ht;
         row = ((ticks - 1) / ht) % vt;
      end
      hs_act        = (col >= g.hv + g.hf) && (col < g.hv + g.hf + g.hs);
      vs_act        = (row >= g.vv + g.vf) && (row < g.vv + g.vf + g.vs);
      e.pix_tick    = ((mm % g.cd) == g.cd - 1);
      e.hsync       = (g.low != 0) ? !hs_act : hs_act;
      e.vsync       = (g.low != 0) ? !vs_act : vs_act;
      e.video_on    = (col < g.hv) && (row < g.vv);
      e.col         = 10'(col);
      e.row         = 10'(row);
      e.wcol        = 7'(col >> g.rz);
      e.wrow        = 7'(row >> g.rz);
      e.in_world    = e.video_on && (col < g.wp) && (row < g.wp);
      e.line_start  = (ticks > 0) && ((mm % g.cd) == 0) && (col == 0);
      e.frame_start = e.line_start && (row == 0);
      return e;
   endfunction

   function automatic vec_t mk(input string n, input int mm, input bit pt, input bit hs,
                               input bit vs, input bit vid, input int col, input int row,
                               input int wc, input int wr, input bit inw, input bit ls,
                               input bit fs);
      vec_t v;
      v.name = n;
      v.m    = mm;
      v.exp  = {pt, hs, vs, vid, 10'(col), 10'(row), 7'(wc), 7'(wr), inw, ls, fs};
      return v;
   endfunction

   task automatic check_vec(input string name, input out_t act, input out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s m=%0d: got %h expected %h", name, m, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s m=%0d: got %0d expected %0d", name, m, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) begin
         m         = 0;
         last_ls_a = -1;
         last_fs_c = -1;
         vs_low_c  = 0;
      end else begin
         m++;
      end
      @(negedge clk);
      check_vec("model_a", act_a, model(m, ga));
      check_vec("model_b", act_b, model(m, gb));
      check_vec("model_c", act_c, model(m, gc));
      if (measure) begin
         if (m < 40 && va.pix_tick) tick_cnt++;
         if (m >= 4 && m < 3204 && !va.hsync) hs_low_a++;
         if (m >= 4 && m < 3204 && vb.hsync) hs_high_b++;
      end
      if (va.line_start) begin
         if (last_ls_a >= 0) check_int("line_period_a", m - last_ls_a, 3200);
         last_ls_a = m;
      end
      if (vc.frame_start) begin
         if (last_fs_c >= 0) begin
            check_int("frame_period_c", m - last_fs_c, 1008);
            check_int("vsync_width_c", vs_low_c, 112);
         end
         last_fs_c = m;
         vs_low_c  = 0;
      end
      if (!vc.vsync) vs_low_c++;
   endtask

   vec_t tbl[17];

   initial begin
      int guard;
      tbl[0]  = mk("reset_hold",   0,     0, 1, 1, 0, 799, 524,  71, 3, 0, 0, 0);
      tbl[1]  = mk("first_tick",   3,     1, 1, 1, 0, 799, 524,  71, 3, 0, 0, 0);
      tbl[2]  = mk("frame_start",  4,     0, 1, 1, 1,   0,   0,   0, 0, 1, 1, 1);
      tbl[3]  = mk("fs_one_clk",   5,     0, 1, 1, 1,   0,   0,   0, 0, 1, 0, 0);
      tbl[4]  = mk("col1",         8,     0, 1, 1, 1,   1,   0,   0, 0, 1, 0, 0);
      tbl[5]  = mk("col300",       1204,  0, 1, 1, 1, 300,   0,  75, 0, 1, 0, 0);
      tbl[6]  = mk("world_edge",   2048,  0, 1, 1, 1, 511,   0, 127, 0, 1, 0, 0);
      tbl[7]  = mk("world_out",    2052,  0, 1, 1, 1, 512,   0,   0, 0, 0, 0, 0);
      tbl[8]  = mk("vis_end",      2560,  0, 1, 1, 1, 639,   0,  31, 0, 0, 0, 0);
      tbl[9]  = mk("blank",        2564,  0, 1, 1, 0, 640,   0,  32, 0, 0, 0, 0);
      tbl[10] = mk("hs_pre",       2624,  0, 1, 1, 0, 655,   0,  35, 0, 0, 0, 0);
      tbl[11] = mk("hs_first",     2628,  0, 0, 1, 0, 656,   0,  36, 0, 0, 0, 0);
      tbl[12] = mk("hs_last",      3008,  0, 0, 1, 0, 751,   0,  59, 0, 0, 0, 0);
      tbl[13] = mk("hs_post",      3012,  0, 1, 1, 0, 752,   0,  60, 0, 0, 0, 0);
      tbl[14] = mk("line_end",     3200,  0, 1, 1, 0, 799,   0,  71, 0, 0, 0, 0);
      tbl[15] = mk("line_start",   3204,  0, 1, 1, 1,   0,   1,   0, 0, 1, 1, 0);
      tbl[16] = mk("row12_col300", 39604, 0, 1, 1, 1, 300,  12,  75, 3, 1, 0, 0);

      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      measure = 1'b1;
      for (int i = 0; i < 17; i++) begin
         while (m < tbl[i].m) step();
         check_vec(tbl[i].name, act_a, tbl[i].exp);
      end
      measure = 1'b0;
      check_int("ticks_in_40", tick_cnt, 10);
      check_int("hsync_low_clks", hs_low_a, 384);
      check_int("hsync_high_clks_pos", hs_high_b, 384);

      // Reset while the default-geometry hsync pulse is in progress.
      guard = 0;
      while (va.pixel_column != 10'd700 && guard < 5000) begin
         step();
         guard++;
      end
      check_int("wait_col700", int'(va.pixel_column), 700);
      check_int("hsync_low_col700", int'(va.hsync), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_int("rst_hsync", int'(va.hsync), 1);
      check_int("rst_col", int'(va.pixel_column), 799);
      check_int("rst_row", int'(va.pixel_row), 524);
      guard = 0;
      while (!va.frame_start && guard < 20) begin
         step();
         guard++;
      end
      check_int("fs_after_reset", guard, 4);

      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 2999) == 0) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            rst = 1'b0;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
